// File: rtl/mem_port_arbiter.sv
// Arbiter for one shared variable-latency memory port between fetch and data.
// Data access wins; the pipeline stalls until every pending request is served.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_done_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              err_o
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DM_BUSY,
        IF_BUSY
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              if_served_q;
    logic              dm_served_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              err_q;

    logic dm_req;
    logic stall;
    logic timeout;

    assign dm_req  = dm_read_i | dm_write_i;
    assign stall   = start_i & ((dm_req & ~dm_served_q) | (if_req_i & ~if_served_q));
    assign timeout = (cnt_q == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            if_served_q <= 1'b0;
            dm_served_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            // Pipeline-advance edge: the next step starts with fresh flags.
            if (!stall) begin
                if_served_q <= 1'b0;
                dm_served_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (dm_req && !dm_served_q) begin
                        mem_addr_q  <= dm_addr_i;
                        mem_wdata_q <= dm_wdata_i;
                        mem_we_q    <= dm_write_i;
                        mem_req_q   <= 1'b1;
                        state_q     <= DM_BUSY;
                    end else if (if_req_i && !if_served_q) begin
                        mem_addr_q <= if_addr_i;
                        mem_we_q   <= 1'b0;
                        mem_req_q  <= 1'b1;
                        state_q    <= IF_BUSY;
                    end
                end
                DM_BUSY, IF_BUSY: begin
                    if (mem_ack_i || timeout) begin
                        mem_req_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                        if (!mem_ack_i) begin
                            err_q <= 1'b1;
                        end
                        if (state_q == DM_BUSY) begin
                            dm_served_q <= 1'b1;
                            if (!mem_we_q) begin
                                dm_rdata_q <= mem_ack_i ? mem_rdata_i : '0;
                            end
                        end else begin
                            if_served_q <= 1'b1;
                            if_rdata_q  <= mem_ack_i ? mem_rdata_i : '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_rdata_o  = if_rdata_q;
    assign if_valid_o  = if_served_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign dm_done_o   = dm_served_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign stall_o     = stall;
    assign err_o       = err_q;

endmodule
